// File: rtl/dnn_accel_onchip_memory_dp.sv
// Dual-port Avalon-MM on-chip RAM (s1: Nios II data master, s2: DNN datapath) with byte enables.
// Optional power-up clear engine: define DNN_MEM_CLEAR_EN.
module dnn_accel_onchip_memory_dp #(
  parameter int    DATA_W       = 32,
  parameter int    ADDR_W       = 13,
  parameter int    DEPTH        = 8192,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = "dnn_accel_onchip_memory_dp.hex"
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clken,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  output logic                s1_waitrequest,
  input  logic [ADDR_W-1:0]   s2_address,
  input  logic                s2_chipselect,
  input  logic                s2_read,
  input  logic                s2_write,
  input  logic [DATA_W/8-1:0] s2_byteenable,
  input  logic [DATA_W-1:0]   s2_writedata,
  output logic [DATA_W-1:0]   s2_readdata,
  output logic                s2_readdatavalid,
  output logic                s2_waitrequest,
  output logic [1:0]          dbg_state
);
  localparam int NB = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, READY = 2'd2} state_t;

  // INIT_FILE is bound to mem by the device flow's memory-initialisation step.
  if ((DATA_W % 8) != 0 || DEPTH > (1 << ADDR_W) || DEPTH < 1 ||
      (READ_LATENCY != 1 && READ_LATENCY != 2) || INIT_FILE == "") begin : g_bad_params
    $error("dnn_accel_onchip_memory_dp: illegal parameter set");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  // Index 0 is s1, index 1 is s2.
  logic [ADDR_W-1:0] addr  [2];
  logic [NB-1:0]     be    [2];
  logic [DATA_W-1:0] wdata [2];
  logic              cs [2];
  logic              rd [2];
  logic              wr [2];

  assign addr[0]  = s1_address;    assign addr[1]  = s2_address;
  assign be[0]    = s1_byteenable; assign be[1]    = s2_byteenable;
  assign wdata[0] = s1_writedata;  assign wdata[1] = s2_writedata;
  assign cs[0]    = s1_chipselect; assign cs[1]    = s2_chipselect;
  assign rd[0]    = s1_read;       assign rd[1]    = s2_read;
  assign wr[0]    = s1_write;      assign wr[1]    = s2_write;

  logic             busy;
  logic             clr_we;
  logic [IDX_W-1:0] clr_addr;

`ifdef DNN_MEM_CLEAR_EN
  state_t state;

  // IDLE and CLEAR both sweep; IDLE only marks that the sweep has not advanced yet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      clr_addr <= '0;
    end else if (clken) begin
      case (state)
        IDLE, CLEAR: begin
          if (clr_addr == IDX_W'(DEPTH - 1)) begin
            state <= READY;
          end else begin
            state    <= CLEAR;
            clr_addr <= clr_addr + 1'b1;
          end
        end
        default: state <= READY;
      endcase
    end
  end

  assign busy      = (state != READY);
  assign clr_we    = reset_n & clken & (state != READY);
  assign dbg_state = state;
`else
  assign busy      = 1'b0;
  assign clr_we    = 1'b0;
  assign clr_addr  = '0;
  assign dbg_state = READY;
`endif

  // Waitrequest depends only on registered state and the global enable.
  assign s1_waitrequest = busy | ~clken;
  assign s2_waitrequest = busy | ~clken;

  logic             in_rng  [2];
  logic             acc     [2];
  logic             wr_acc  [2];
  logic             rd_acc  [2];
  logic [IDX_W-1:0] idx     [2];
  logic [DATA_W-1:0] rd_word [2];

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      in_rng[p]  = ({1'b0, addr[p]} < DEPTH_X);
      idx[p]     = addr[p][IDX_W-1:0];
      acc[p]     = reset_n & clken & ~busy & cs[p] & (rd[p] | wr[p]);
      wr_acc[p]  = acc[p] & wr[p] & in_rng[p];
      rd_acc[p]  = acc[p] & rd[p] & ~wr[p];
      rd_word[p] = in_rng[p] ? mem[idx[p]] : '0;
    end
  end

  // s2 is applied first so s1's lanes overwrite it on a same-address collision.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      for (int p = 1; p >= 0; p--) begin
        for (int b = 0; b < NB; b++) begin
          if (wr_acc[p] && be[p][b]) mem[idx[p]][b*8 +: 8] <= wdata[p][b*8 +: 8];
        end
      end
    end
  end

  logic [DATA_W-1:0] rdata_q  [2];
  logic              rvalid_q [2];

  if (READ_LATENCY == 2) begin : g_rl2
    logic [DATA_W-1:0] stage_data  [2];
    logic              stage_valid [2];

    // A stalled stage holds its read; the output pulse is re-issued on the next enabled edge.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int p = 0; p < 2; p++) begin
          stage_data[p]  <= '0;
          stage_valid[p] <= 1'b0;
          rdata_q[p]     <= '0;
          rvalid_q[p]    <= 1'b0;
        end
      end else begin
        for (int p = 0; p < 2; p++) begin
          rvalid_q[p] <= clken & stage_valid[p];
          if (clken && stage_valid[p]) rdata_q[p] <= stage_data[p];
          if (clken) begin
            stage_valid[p] <= rd_acc[p];
            if (rd_acc[p]) stage_data[p] <= rd_word[p];
          end
        end
      end
    end
  end else begin : g_rl1
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int p = 0; p < 2; p++) begin
          rdata_q[p]  <= '0;
          rvalid_q[p] <= 1'b0;
        end
      end else begin
        for (int p = 0; p < 2; p++) begin
          rvalid_q[p] <= rd_acc[p];
          if (rd_acc[p]) rdata_q[p] <= rd_word[p];
        end
      end
    end
  end

  assign s1_readdata      = rdata_q[0];
  assign s1_readdatavalid = rvalid_q[0];
  assign s2_readdata      = rdata_q[1];
  assign s2_readdatavalid = rvalid_q[1];
endmodule
